// File: rtl/dkong_snd_pkg.sv
// Shared types and constants for the Donkey Kong sound ROM arbiter.
// Used by dkong_snd_rom_arbiter and dkong_snd_rom_port.
package dkong_snd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_WAIT,
        WAV_WAIT
    } rom_arb_state_t;

    localparam int         ROM_AW       = 20;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/dkong_snd_rom_port.sv
// One requester slot: pending flag, address latch, data/valid register.
// Optional one-entry tag when DKSND_ROM_CACHE_EN is defined.
module dkong_snd_rom_port
    import dkong_snd_pkg::*;
#(
    parameter int                AW   = 12,
    parameter logic [ROM_AW-1:0] BASE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [AW-1:0]     addr,
    input  logic              grant,
    input  logic              done,
    input  logic              tmo,
    input  logic              flush,
    input  logic [7:0]        mem_data,
    output logic              pending,
    output logic [ROM_AW-1:0] full_addr,
    output logic [7:0]        data,
    output logic              valid
);

    logic [AW-1:0] addr_q;
    logic          hit;
    logic [7:0]    hit_data;

    assign full_addr = ROM_AW'(addr_q) + BASE;

`ifdef DKSND_ROM_CACHE_EN
    logic [AW-1:0] fl_addr;
    logic [AW-1:0] tag_addr;
    logic [7:0]    tag_data;
    logic          tag_v;

    // A completing access takes the data path this cycle, so no hit then.
    assign hit      = req && tag_v && (addr == tag_addr) && !done && !flush;
    assign hit_data = tag_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_addr  <= '0;
            tag_addr <= '0;
            tag_data <= 8'h00;
            tag_v    <= 1'b0;
        end else begin
            if (grant)
                fl_addr <= addr_q;
            if (flush) begin
                tag_v <= 1'b0;
            end else if (done) begin
                tag_v    <= 1'b1;
                tag_addr <= fl_addr;
                tag_data <= mem_data;
            end
        end
    end
`else
    logic unused_flush;

    assign hit          = 1'b0;
    assign hit_data     = 8'h00;
    assign unused_flush = flush;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            addr_q  <= '0;
            data    <= 8'h00;
            valid   <= 1'b0;
        end else begin
            // A new strobe beats the grant clear: it queues behind the access.
            if (req && !hit) begin
                pending <= 1'b1;
                addr_q  <= addr;
            end else if (grant) begin
                pending <= 1'b0;
            end
            valid <= done || tmo || hit;
            if (done)
                data <= mem_data;
            else if (tmo)
                data <= TIMEOUT_DATA;
            else if (hit)
                data <= hit_data;
        end
    end

endmodule

// File: rtl/dkong_snd_rom_arbiter.sv
// Shares the byte-wide sound ROM between 8035 program fetch and WAV fetch.
// Optional per-requester one-entry cache: define DKSND_ROM_CACHE_EN.
module dkong_snd_rom_arbiter
    import dkong_snd_pkg::*;
#(
    parameter logic [ROM_AW-1:0] CPU_BASE    = 20'h00000,
    parameter logic [ROM_AW-1:0] WAV_BASE    = 20'h10000,
    parameter int                MAX_CPU_RUN = 4,
    parameter int                TIMEOUT     = 255
) (
    input  logic              W_CLK_24576M,
    input  logic              W_RESETn,
    input  logic              cpu_req,
    input  logic [11:0]       cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_valid,
    input  logic              wav_req,
    input  logic [18:0]       wav_addr,
    output logic [7:0]        wav_data,
    output logic              wav_valid,
    output logic              mem_req,
    output logic [ROM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              err_timeout
);

    rom_arb_state_t    state_q, state_n;
    logic [3:0]        run_q, run_n;
    logic [7:0]        tmo_q, tmo_n;
    logic              mem_req_n;
    logic [ROM_AW-1:0] mem_addr_n;
    logic              err_n;

    logic              cpu_pend, wav_pend;
    logic [ROM_AW-1:0] cpu_full, wav_full;
    logic              grant_cpu, grant_wav;
    logic              tmo_hit;

    assign grant_cpu = (state_q == IDLE) && cpu_pend &&
                       (!wav_pend || run_q < 4'(MAX_CPU_RUN));
    assign grant_wav = (state_q == IDLE) && wav_pend && !grant_cpu;
    assign tmo_hit   = (state_q != IDLE) && !mem_ack &&
                       (tmo_q == 8'(TIMEOUT - 1));

    dkong_snd_rom_port #(
        .AW   (12),
        .BASE (CPU_BASE)
    ) u_cpu_port (
        .clk       (W_CLK_24576M),
        .rst_n     (W_RESETn),
        .req       (cpu_req),
        .addr      (cpu_addr),
        .grant     (grant_cpu),
        .done      (state_q == CPU_WAIT && mem_ack),
        .tmo       (state_q == CPU_WAIT && tmo_hit),
        .flush     (tmo_hit),
        .mem_data  (mem_data),
        .pending   (cpu_pend),
        .full_addr (cpu_full),
        .data      (cpu_data),
        .valid     (cpu_valid)
    );

    dkong_snd_rom_port #(
        .AW   (19),
        .BASE (WAV_BASE)
    ) u_wav_port (
        .clk       (W_CLK_24576M),
        .rst_n     (W_RESETn),
        .req       (wav_req),
        .addr      (wav_addr),
        .grant     (grant_wav),
        .done      (state_q == WAV_WAIT && mem_ack),
        .tmo       (state_q == WAV_WAIT && tmo_hit),
        .flush     (tmo_hit),
        .mem_data  (mem_data),
        .pending   (wav_pend),
        .full_addr (wav_full),
        .data      (wav_data),
        .valid     (wav_valid)
    );

    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state_q     <= IDLE;
            run_q       <= '0;
            tmo_q       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_n;
            run_q       <= run_n;
            tmo_q       <= tmo_n;
            mem_req     <= mem_req_n;
            mem_addr    <= mem_addr_n;
            err_timeout <= err_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        run_n      = run_q;
        tmo_n      = tmo_q;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        err_n      = err_timeout;

        unique case (state_q)
            IDLE: begin
                tmo_n = '0;
                if (grant_cpu) begin
                    state_n    = CPU_WAIT;
                    mem_req_n  = 1'b1;
                    mem_addr_n = cpu_full;
                end else if (grant_wav) begin
                    state_n    = WAV_WAIT;
                    mem_req_n  = 1'b1;
                    mem_addr_n = wav_full;
                end
            end
            CPU_WAIT, WAV_WAIT: begin
                // Ack on the timeout cycle still delivers real data.
                if (mem_ack) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                end else if (tmo_hit) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    err_n     = 1'b1;
                end else begin
                    tmo_n = tmo_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (grant_wav || !wav_pend)
            run_n = '0;
        else if (grant_cpu && run_q < 4'(MAX_CPU_RUN))
            run_n = run_q + 4'd1;
    end

endmodule

// File: tb/tb_dkong_snd_rom_arbiter.sv
// Directed self-checking bench for dkong_snd_rom_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dkong_snd_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_data;
    logic        cpu_valid;
    logic        wav_req = 1'b0;
    logic [18:0] wav_addr = '0;
    logic [7:0]  wav_data;
    logic        wav_valid;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    dkong_snd_rom_arbiter dut (
        .W_CLK_24576M (clk),
        .W_RESETn     (rst_n),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_valid    (cpu_valid),
        .wav_req      (wav_req),
        .wav_addr     (wav_addr),
        .wav_data     (wav_data),
        .wav_valid    (wav_valid),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .err_timeout  (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_cdat"}, 32'(cpu_data), 32'h00);
        chk({tag, "_wdat"}, 32'(wav_data), 32'h00);
        chk({tag, "_vld"}, 32'({cpu_valid, wav_valid}), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        int     n;
        logic   is_wav;
        logic   exp_wav;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // CPU only, ack after 2 cycles
        cpu_req = 1'b1; cpu_addr = 12'h123;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("cpu_pend_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("cpu_req", 32'(mem_req), 32'd1);
        chk("cpu_addr", 32'(mem_addr), 32'h00123);
        repeat (2) @(negedge clk);
        chk("cpu_hold", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_data = 8'hA5;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("cpu_drop", 32'(mem_req), 32'd0);
        chk("cpu_vld", 32'(cpu_valid), 32'd1);
        chk("cpu_data", 32'(cpu_data), 32'hA5);
        chk("cpu_wvld", 32'(wav_valid), 32'd0);
        @(negedge clk);
        chk("cpu_vld_once", 32'(cpu_valid), 32'd0);
        chk("cpu_hold_data", 32'(cpu_data), 32'hA5);

        // Minimum latency: 0-wait memory, valid 3 cycles after strobe
        cpu_req = 1'b1; cpu_addr = 12'h321;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("lat_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_data = 8'h3C;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lat_vld", 32'(cpu_valid), 32'd1);
        chk("lat_data", 32'(cpu_data), 32'h3C);

        // WAV only, top address plus base
        @(negedge clk);
        wav_req = 1'b1; wav_addr = 19'h7FFFF;
        @(negedge clk);
        wav_req = 1'b0;
        @(negedge clk);
        chk("wav_req", 32'(mem_req), 32'd1);
        chk("wav_addr", 32'(mem_addr), 32'h8FFFF);
        mem_ack = 1'b1; mem_data = 8'h5A;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wav_vld", 32'(wav_valid), 32'd1);
        chk("wav_data", 32'(wav_data), 32'h5A);
        chk("wav_cvld", 32'(cpu_valid), 32'd0);
        @(negedge clk);
        chk("wav_vld_once", 32'(wav_valid), 32'd0);

        // Contention: expected grant order C C C C W C C C C W
        cpu_req = 1'b1; cpu_addr = 12'h0A0;
        wav_req = 1'b1; wav_addr = 19'h00100;
        @(negedge clk);
        cpu_req = 1'b0; wav_req = 1'b0;
        for (int g = 0; g < 10; g++) begin
            wait_req($sformatf("cont_req%0d", g));
            is_wav  = mem_addr[16];
            exp_wav = (g % 5 == 4);
            chk($sformatf("cont_grant%0d", g), 32'(is_wav), 32'(exp_wav));
            mem_ack = 1'b1; mem_data = 8'(g);
            if (is_wav) begin
                wav_req = 1'b1; wav_addr = 19'h00101 + 19'(g);
            end else begin
                cpu_req = 1'b1; cpu_addr = 12'h0A1 + 12'(g);
            end
            @(negedge clk);
            mem_ack = 1'b0; cpu_req = 1'b0; wav_req = 1'b0;
        end
        // Drain the requests still pending
        for (int g = 0; g < 2; g++) begin
            wait_req($sformatf("drain%0d", g));
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("drain_idle", 32'(mem_req), 32'd0);

        // Stray ack in IDLE
        mem_ack = 1'b1; mem_data = 8'h33;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_vld", 32'({cpu_valid, wav_valid}), 32'd0);
        chk("idle_ack_req", 32'(mem_req), 32'd0);

        // Timeout: memory never acks
        cpu_req = 1'b1; cpu_addr = 12'h200;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_req("to_req");
        n = 0;
        while (mem_req && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("to_len", 32'(n), 32'd255);
        chk("to_vld", 32'(cpu_valid), 32'd1);
        chk("to_data", 32'(cpu_data), 32'hFF);
        chk("to_err", 32'(err_timeout), 32'd1);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);

        // Ack on the timeout cycle wins
        cpu_req = 1'b1; cpu_addr = 12'h201;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_req("tack_req");
        repeat (254) @(negedge clk);
        chk("tack_still", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_data = 8'h6B;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("tack_vld", 32'(cpu_valid), 32'd1);
        chk("tack_data", 32'(cpu_data), 32'h6B);

        // Reset in CPU_WAIT
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 12'h0F0;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_req("mrst_req");
        rst_n = 1'b0;
        #1;
        chk("mrst_async", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 8'h77;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk_reset_vals("mrst");

`ifdef DKSND_ROM_CACHE_EN
        // Cache: second read of the same address is served from the tag
        cpu_req = 1'b1; cpu_addr = 12'h040;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_req("c_req");
        chk("c_addr", 32'(mem_addr), 32'h00040);
        mem_ack = 1'b1; mem_data = 8'hC3;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("c_data", 32'(cpu_data), 32'hC3);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 12'h040;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("c_hit_vld", 32'(cpu_valid), 32'd1);
        chk("c_hit_data", 32'(cpu_data), 32'hC3);
        chk("c_hit_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("c_hit_noreq2", 32'(mem_req), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
